serial_tx: RTL and testbench
============================

# serial_tx

Framed serial transmitter: accepts one parallel word through a valid/ready handshake and shifts it out on a single line. The frame is a start bit (0), DATA_W data bits LSB-first, and a stop bit (1). Each bit is held for CLKS_PER_BIT clock cycles. It is the transmit end of the team's serial link and drives the line that the shift-register serial receiver samples.

## Interface
- DATA_W, default 8: data bits per frame; must be ≥1.
- CLKS_PER_BIT, default 4: clock cycles per serial bit; must be ≥2 (elaboration-time assertion).

- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset; asynchronous, active-high.
- tx_data  input  DATA_W  word to send; sampled only at the accept edge.
- tx_valid  input  1  upstream has a word.
- tx_ready  output  1  block can accept a word this cycle.
- tx_serial  output  1  serial line; idles high.
- tx_busy  output  1  a frame is in progress (START, DATA or STOP state).
- tx_done  output  1  one-cycle pulse when a frame completes.

## Operation
- Reset values, applied immediately on rst assertion: tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, bit counter=0, timer=0.
- Accept: at a posedge where tx_valid && tx_ready, tx_data is latched into a shift register.
- States: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: tx_serial=1, tx_ready=1. An accept moves to START.
  - START: tx_serial=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx_serial=shreg[0]. The register shifts right every CLKS_PER_BIT cycles. After DATA_W bits, move to STOP.
  - STOP: tx_serial=1 for CLKS_PER_BIT cycles, then IDLE with tx_done=1 for one cycle.
- tx_ready=0 and tx_busy=1 in every non-IDLE state.
- tx_valid while busy is ignored. Upstream must hold tx_valid and tx_data until tx_ready.
- Changes to tx_data after the accept edge have no effect on the frame in flight.
- Bit timer counts 0..CLKS_PER_BIT-1 and wraps. bit_tick asserts at count CLKS_PER_BIT-1.
- Bit counter width is $clog2(DATA_W+1).
- Reset mid-frame aborts the frame: line returns high asynchronously, no tx_done, the next accept starts a clean frame.
- All outputs are registered. No combinational path from any input to any output.

## Timing
- Let E0 be the accept edge and C = CLKS_PER_BIT.
- tx_serial=0 from E0 to E0+C.
- Data bit i is driven from E0+(1+i)C to E0+(2+i)C.
- Stop bit is driven from E0+(DATA_W+1)C to E0+(DATA_W+2)C.
- At edge E0+(DATA_W+2)C the state is IDLE, tx_ready=1 and tx_done=1, for that single cycle only.
- Back-to-back frames: the earliest next accept is edge E0+(DATA_W+2)C+1.
  - This gives exactly one extra idle-high cycle between frames.
  - Inter-frame period = (DATA_W+2)C+1 cycles with tx_valid held high.
- tx_busy falls on the same edge that tx_done rises.

## Structure
- Package serial_pkg holds:
  - typedef enum logic [1:0] tx_state_e {IDLE, START, DATA, STOP};
  - constants START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1.
  - The receiver imports the same package.
- Sub-module bit_timer (parameter CLKS_PER_BIT) contains the wrapping counter.
  - Inputs: clk, rst, clear.
  - Output: bit_tick.
  - serial_tx asserts clear on accept so every bit period starts aligned to E0.

## Test plan
All scenarios use DATA_W=8, CLKS_PER_BIT=4.
- Reset check: assert rst mid-cycle -> tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0 within the same timestep, before any clock edge.
- Single frame: tx_data=0xA5 accepted at E0 -> tx_serial sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; tx_done single pulse at E0+40; tx_ready low during E0..E0+39.
- Back-to-back: 0x00 then 0xFF with tx_valid held -> second start bit begins at E0+41 and the second frame is 0,1×8,1.
- Ignore while busy: tx_data changed to 0x3C and tx_valid pulsed mid-frame -> frame still carries the original word, no extra accept, one tx_done only.
- Reset mid-frame: rst asserted during data bit 3 -> tx_serial=1 immediately, no tx_done. Afterward 0x3C transmits correctly (0,0,0,1,1,1,1,0,0,1).
- Idle line: no tx_valid for 100 cycles -> tx_serial constantly 1, tx_done never asserted.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial link (transmitter and receiver).
package serial_pkg;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/serial_tx_bit_timer.sv
// Wrapping bit-period counter; bit_tick marks the last cycle of each serial bit.
module bit_timer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic bit_tick
);
   localparam int CNT_W = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] count_reg;

   generate
      if (CLKS_PER_BIT < 2) begin : g_bad_clks
         $error("bit_timer: CLKS_PER_BIT must be >= 2");
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count_reg <= '0;
      else if (clear || count_reg == LAST)
         count_reg <= '0;
      else
         count_reg <= count_reg + 1'b1;
   end

   assign bit_tick = (count_reg == LAST);
endmodule

// File: rtl/serial_tx.sv
// Framed serial transmitter: start bit, DATA_W data bits LSB-first, stop bit.
module serial_tx
   import serial_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              tx_serial,
   output logic              tx_busy,
   output logic              tx_done
);
   localparam int BIT_CNT_W = $clog2(DATA_W + 1);
   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W);

   tx_state_e             state_reg;
   logic [DATA_W-1:0]     shreg_reg;
   logic [BIT_CNT_W-1:0]  bit_cnt_reg;
   logic                  accept;
   logic                  bit_tick;

   generate
      if (DATA_W < 1) begin : g_bad_width
         $error("serial_tx: DATA_W must be >= 1");
      end
      if (CLKS_PER_BIT < 2) begin : g_bad_clks
         $error("serial_tx: CLKS_PER_BIT must be >= 2");
      end
   endgenerate

   assign accept = tx_valid && tx_ready;

   // Clearing on accept aligns every bit boundary to the accept edge.
   bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
      .clk      (clk),
      .rst      (rst),
      .clear    (accept),
      .bit_tick (bit_tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         shreg_reg   <= '0;
         bit_cnt_reg <= '0;
         tx_serial   <= IDLE_LEVEL;
         tx_ready    <= 1'b1;
         tx_busy     <= 1'b0;
         tx_done     <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  shreg_reg   <= tx_data;
                  bit_cnt_reg <= '0;
                  tx_serial   <= START_BIT;
                  tx_ready    <= 1'b0;
                  tx_busy     <= 1'b1;
                  state_reg   <= START;
               end
            end
            START: begin
               if (bit_tick) begin
                  tx_serial   <= shreg_reg[0];
                  shreg_reg   <= shreg_reg >> 1;
                  bit_cnt_reg <= bit_cnt_reg + 1'b1;
                  state_reg   <= DATA;
               end
            end
            DATA: begin
               // bit_cnt_reg counts bits already put on the line.
               if (bit_tick) begin
                  if (bit_cnt_reg == LAST_BIT) begin
                     tx_serial <= STOP_BIT;
                     state_reg <= STOP;
                  end else begin
                     tx_serial   <= shreg_reg[0];
                     shreg_reg   <= shreg_reg >> 1;
                     bit_cnt_reg <= bit_cnt_reg + 1'b1;
                  end
               end
            end
            STOP: begin
               if (bit_tick) begin
                  tx_serial   <= IDLE_LEVEL;
                  tx_ready    <= 1'b1;
                  tx_busy     <= 1'b0;
                  tx_done     <= 1'b1;
                  bit_cnt_reg <= '0;
                  state_reg   <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: stimulus queues expected words, a monitor checks the line.
module tb_serial_tx;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       tx_serial;
   logic       tx_busy;
   logic       tx_done;

   typedef struct {
      logic [7:0] data;
      bit         abort;
   } exp_t;

   exp_t q[$];
   int   starts[$];
   int   checks = 0;
   int   errors = 0;
   int   gcyc = 0;
   int   done_cnt = 0;
   int   exp_done = 0;

   bit         in_frame = 0;
   bit         done_chk = 0;
   bit         post_chk = 0;
   int         cyc = 0;
   exp_t       cur;
   logic [9:0] frame_bits;

   serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .tx_serial (tx_serial),
      .tx_busy   (tx_busy),
      .tx_done   (tx_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) gcyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Monitor: one check per frame cycle plus the done-pulse window after each frame.
   always @(negedge clk) begin
      if (rst) begin
         if (in_frame && !cur.abort) check("frame_aborted_unexpectedly", 1, 0);
         in_frame = 0;
         done_chk = 0;
         post_chk = 0;
      end else begin
         if (tx_done === 1'b1) done_cnt++;
         if (done_chk) begin
            check("done_pulse_rdy_busy", {29'd0, tx_done, tx_ready, tx_busy}, 32'b110);
            done_chk = 0;
            post_chk = 1;
         end else if (post_chk) begin
            check("done_single_cycle", {31'd0, tx_done}, 0);
            post_chk = 0;
         end
         if (!in_frame && tx_busy === 1'b1) begin
            if (q.size() == 0) begin
               check("unexpected_frame", 1, 0);
               cur = '{data: 8'h00, abort: 1'b0};
            end else begin
               cur = q.pop_front();
            end
            starts.push_back(gcyc);
            frame_bits = {1'b1, cur.data, 1'b0};
            in_frame = 1;
            cyc = 0;
         end
         if (in_frame) begin
            check($sformatf("frame_%02h_bit%0d_cyc%0d", cur.data, cyc / 4, cyc % 4),
                  {28'd0, tx_serial, tx_ready, tx_busy, tx_done},
                  {28'd0, frame_bits[cyc / 4], 3'b010});
            cyc++;
            if (cyc == 40) begin
               in_frame = 0;
               done_chk = 1;
               if (cur.abort) check("abort_expected_not_seen", 1, 0);
            end
         end
      end
   end

   task automatic send(input logic [7:0] d, input bit ab, input bit hold);
      int n = 0;
      @(negedge clk);
      tx_data  = d;
      tx_valid = 1'b1;
      q.push_back('{data: d, abort: ab});
      if (!ab) exp_done++;
      while (tx_ready !== 1'b1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("accept_timeout", {31'd0, n >= 500}, 0);
      @(posedge clk);
      #1;
      if (!hold) tx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((tx_busy !== 1'b0 || in_frame || q.size() != 0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("idle_wait_timeout", {31'd0, n >= 500}, 0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int bad;
      int s;
      // Reset asserted mid-cycle, checked before any clock edge.
      #1 rst = 1'b1;
      #1;
      check("reset_outputs", {28'd0, tx_serial, tx_ready, tx_busy, tx_done}, 32'b1100);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      repeat (2) @(negedge clk);

      // Single frame.
      send(8'hA5, 1'b0, 1'b0);
      wait_idle();

      // Back-to-back with tx_valid held.
      send(8'h00, 1'b0, 1'b1);
      send(8'hFF, 1'b0, 1'b1);
      tx_valid = 1'b0;
      wait_idle();
      s = starts.size();
      if (s >= 2) check("b2b_start_gap", starts[s-1] - starts[s-2], 41);
      else check("b2b_frames_seen", s, 2);

      // Mid-frame tx_valid pulse with different data is ignored.
      send(8'h96, 1'b0, 1'b0);
      repeat (12) @(posedge clk);
      #1 tx_data = 8'h3C;
      tx_valid = 1'b1;
      @(posedge clk);
      #1 tx_valid = 1'b0;
      wait_idle();

      // Reset during data bit 3 of 0xA5 (bit 3 is 0, so the line visibly returns high).
      send(8'hA5, 1'b1, 1'b0);
      repeat (17) @(posedge clk);
      #1;
      check("pre_abort_line_low", {31'd0, tx_serial}, 0);
      rst = 1'b1;
      #1;
      check("abort_outputs_async", {28'd0, tx_serial, tx_ready, tx_busy, tx_done}, 32'b1100);
      @(negedge clk);
      @(negedge clk) rst = 1'b0;
      send(8'h3C, 1'b0, 1'b0);
      wait_idle();

      // Idle line stays high with no tx_done.
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tx_serial !== 1'b1 || tx_done !== 1'b0 || tx_busy !== 1'b0) bad++;
      end
      check("idle_line_violations", bad, 0);

      check("done_pulse_count", done_cnt, exp_done);
      check("frames_started", starts.size(), 6);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
